// File: rtl/weight_bank_if.sv
// weight_bank_if: command/response handshake plus the shared weight-register bus.
//   master modport: the controller (weight_bank_ctrl) view.
//   slave modport : the command source / weight-bank side view.
// Signals
//   cmd_valid/cmd_ready/cmd_op/cmd_idx/cmd_data : command port
//   rsp_valid/rsp_ready/rsp_data/rsp_err        : response port
//   w_wr, load[N_W], read[N_W], w_rd, set_bank   : weight bank bus
//   busy                                         : controller not idle
interface weight_bank_if #(
  parameter int N_W   = 4,
  parameter int IDX_W = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [IDX_W-1:0] cmd_idx;
  logic [31:0]      cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic [31:0]      w_wr;
  logic [N_W-1:0]   load;
  logic [N_W-1:0]   read;
  logic [31:0]      w_rd;
  logic             set_bank;
  logic             busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_idx, cmd_data, rsp_ready, w_rd,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, w_wr, load, read,
           set_bank, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_idx, cmd_data, rsp_ready, w_rd,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, w_wr, load, read,
           set_bank, busy
  );
endinterface

// File: rtl/weight_bank_ctrl.sv
// weight_bank_ctrl: master-side controller for a bank of N_W weight registers.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : weight_bank_if.master
//     command port  (cmd_valid/ready, op 00=write 01=read 10=write-verify 11=nop)
//     response port (rsp_valid/ready, rsp_data, rsp_err), held until accepted
//     bank bus      (w_wr, one-hot load/read strobes, w_rd capture, set_bank pulse)
//     busy          : FSM not in IDLE
// One command in flight. Latency accept->rsp_valid: write 2, read 2, write-verify 3.
module weight_bank_ctrl #(
  parameter int N_W   = 4,
  parameter int IDX_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  weight_bank_if.master bus
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_PRESET,
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_WVERIFY = 2'b10,
    OP_NOP     = 2'b11
  } op_t;

  localparam logic [IDX_W:0] N_W_L = (IDX_W+1)'(N_W);

  state_t           state_q, state_d;
  op_t              op_q;
  op_t              cmd_op;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rsp_data_q;
  logic             rsp_err_q;
  logic [N_W-1:0]   sel_oh;
  logic             idx_bad;

  // control strobes from the next-state logic into the datapath
  logic             accept;
  logic             ld_wdata;
  logic             cap_bad;
  logic             cap_wr;
  logic             cap_rd;

  assign cmd_op  = op_t'(bus.cmd_op);
  assign idx_bad = ({1'b0, bus.cmd_idx} >= N_W_L);

  always_comb begin
    sel_oh = '0;
    for (int unsigned i = 0; i < N_W; i++) begin
      sel_oh[i] = (idx_q == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // INIT spans reset plus the first cycle after release, so set_bank (decoded
  // from PRESET) is low during reset and on the first edge, then high for
  // exactly one cycle.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    ld_wdata = 1'b0;
    cap_bad  = 1'b0;
    cap_wr   = 1'b0;
    cap_rd   = 1'b0;

    unique case (state_q)
      ST_INIT:   state_d = ST_PRESET;
      ST_PRESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept = 1'b1;
          if (cmd_op == OP_NOP) begin
            state_d = ST_IDLE;
          end else if (idx_bad) begin
            cap_bad = 1'b1;
            state_d = ST_RESP;
          end else if (cmd_op == OP_READ) begin
            state_d = ST_RD;
          end else begin
            ld_wdata = 1'b1;
            state_d  = ST_WR;
          end
        end
      end
      ST_WR: begin
        if (op_q == OP_WVERIFY) begin
          state_d = ST_RD;
        end else begin
          cap_wr  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RD: begin
        cap_rd  = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == ST_IDLE);
    bus.busy      = (state_q != ST_IDLE);
    bus.set_bank  = (state_q == ST_PRESET);
    bus.load      = (state_q == ST_WR) ? sel_oh : '0;
    bus.read      = (state_q == ST_RD) ? sel_oh : '0;
    bus.rsp_valid = (state_q == ST_RESP);
    bus.rsp_data  = rsp_data_q;
    bus.rsp_err   = rsp_err_q;
    bus.w_wr      = wdata_q;
  end

  // wdata_q doubles as the w_wr driver and the write-verify reference; it is
  // only updated by commands that reach WR, so w_wr keeps the last written value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_WRITE;
      idx_q      <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= cmd_op;
        idx_q <= bus.cmd_idx;
      end
      if (ld_wdata) begin
        wdata_q <= bus.cmd_data;
      end
      if (cap_bad) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b1;
      end
      if (cap_wr) begin
        rsp_data_q <= wdata_q;
        rsp_err_q  <= 1'b0;
      end
      if (cap_rd) begin
        rsp_data_q <= bus.w_rd;
        rsp_err_q  <= (op_q == OP_WVERIFY) && (bus.w_rd != wdata_q);
      end
    end
  end

  a_strobe_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({bus.load, bus.read}));

  a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
    bus.cmd_ready |-> !bus.rsp_valid);

endmodule
